// File: rtl/whack_input_stage.sv
// whack_input_stage
//   Input front end for a whack-a-mole style game: four raw pushbuttons are
//   synchronized and debounced into clean levels and one-cycle press pulses,
//   and a round timer counts down a fixed number of ticks after a start
//   request.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable clocks needed to accept a key change
//   TICK_CYCLES     : clocks per round-timer tick
//   ROUND_TICKS     : round length in ticks (1..255)
//
// Ports
//   clk             : system clock, rising edge
//   reset           : synchronous active-high reset
//   key_n[3:0]      : raw asynchronous pushbuttons, active-low
//   timer_start     : one-cycle request to load and run the round timer
//   timer_stop      : one-cycle request to abort the round timer (beats start)
//   key_level[3:0]  : debounced key state, 1 = pressed
//   key_press[3:0]  : one-cycle pulse per accepted press
//   timer_running   : 1 while the timer is in RUN
//   timer_remaining : ticks left in the round
//   timer_expired   : one-cycle pulse when the round ends
module whack_input_stage #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000000,
  parameter int ROUND_TICKS     = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       timer_start,
  input  logic       timer_stop,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic       timer_running,
  output logic [7:0] timer_remaining,
  output logic       timer_expired
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_CYCLES + 1);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_CYCLES - 1);
  localparam logic [7:0]    ROUND_LOAD = 8'(ROUND_TICKS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Key path registers
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_level;
  logic [3:0]    r_press;

  // Timer registers
  logic [0:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_rem;
  logic          r_expired;

  // Next-state wires
  logic [3:0]    w_mismatch;
  logic [CW-1:0] w_cnt_nxt [4];
  logic [3:0]    w_level_nxt;
  logic [0:0]    w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [7:0]    w_rem_nxt;
  logic          w_expired_nxt;

  // Synchronized keys are active-low, levels active-high: a mismatch is
  // where the inverted synchronized value disagrees with the accepted level.
  assign w_mismatch = ~r_sync2 ^ r_level;

  // Debounce: count consecutive mismatching cycles per key, toggle on the last
  always_comb begin
    w_level_nxt = r_level;
    for (int i = 0; i < 4; i++) begin
      w_cnt_nxt[i] = {CW{1'b0}};
      if (w_mismatch[i]) begin
        if (r_cnt[i] == DEB_LAST) begin
          w_level_nxt[i] = ~r_level[i];
          w_cnt_nxt[i]   = {CW{1'b0}};
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end else begin
        w_cnt_nxt[i] = {CW{1'b0}};
      end
    end
  end

  // Round timer: stop beats start, start beats a running expiry
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_rem_nxt     = r_rem;
    w_expired_nxt = 1'b0;
    if (timer_stop) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = {PW{1'b0}};
      w_rem_nxt   = 8'd0;
    end else if (timer_start) begin
      w_state_nxt = S_RUN;
      w_presc_nxt = {PW{1'b0}};
      w_rem_nxt   = ROUND_LOAD;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_presc == TICK_LAST) begin
            w_presc_nxt = {PW{1'b0}};
            // <= 1 rather than == 1 so a zero count can never wrap to 255
            if (r_rem <= 8'd1) begin
              w_rem_nxt     = 8'd0;
              w_state_nxt   = S_IDLE;
              w_expired_nxt = 1'b1;
            end else begin
              w_rem_nxt = r_rem - 8'd1;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        S_IDLE: begin
          w_presc_nxt = {PW{1'b0}};
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = {PW{1'b0}};
        end
      endcase
    end
  end

  // Key synchronizer, debounce counters, levels and press pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_level <= 4'h0;
      r_press <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      // Pulse lands in the same cycle the level first reads 1
      r_press <= w_level_nxt & ~r_level;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Timer state, prescaler, remaining count and expiry pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_presc   <= {PW{1'b0}};
      r_rem     <= 8'd0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_rem     <= w_rem_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  assign key_level       = r_level;
  assign key_press       = r_press;
  assign timer_running   = (r_state == S_RUN);
  assign timer_remaining = r_rem;
  assign timer_expired   = r_expired;

endmodule

// File: tb/tb_whack_input_stage.sv
module tb_whack_input_stage;

  localparam int DEB   = 4;
  localparam int TICK  = 5;
  localparam int ROUND = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       timer_start;
  logic       timer_stop;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic       timer_running;
  logic [7:0] timer_remaining;
  logic       timer_expired;

  whack_input_stage #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TICK),
    .ROUND_TICKS    (ROUND)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_n          (key_n),
    .timer_start    (timer_start),
    .timer_stop     (timer_stop),
    .key_level      (key_level),
    .key_press      (key_press),
    .timer_running  (timer_running),
    .timer_remaining(timer_remaining),
    .timer_expired  (timer_expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_sync1, m_sync2, m_level, m_press;
  int         m_run [4];
  bit         m_running;
  int         m_rem;
  int         m_elapsed;
  bit         m_expired;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs present at the edge
  task automatic model_edge();
    logic [3:0] nl;
    if (reset) begin
      m_sync1 = 4'hF; m_sync2 = 4'hF; m_level = 4'h0; m_press = 4'h0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_running = 1'b0; m_rem = 0; m_elapsed = 0; m_expired = 1'b0;
    end else begin
      // A key level flips once the synchronized key has disagreed with it
      // for DEB consecutive cycles.
      nl = m_level;
      for (int i = 0; i < 4; i++) begin
        if ((~m_sync2[i]) != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            nl[i] = ~nl[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_press = nl & ~m_level;
      m_level = nl;
      m_sync2 = m_sync1;
      m_sync1 = key_n;
      // Round timer: remaining = ROUND minus whole ticks elapsed since start
      m_expired = 1'b0;
      if (timer_stop) begin
        m_running = 1'b0; m_rem = 0;
      end else if (timer_start) begin
        m_running = 1'b1; m_rem = ROUND; m_elapsed = 0;
      end else if (m_running) begin
        m_elapsed++;
        if (m_elapsed % TICK == 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_running = 1'b0;
            m_expired = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("key_level", key_level, m_level);
    check_eq("key_press", key_press, m_press);
    check_eq("timer_running", timer_running, m_running);
    check_eq("timer_remaining", timer_remaining, m_rem[7:0]);
    check_eq("timer_expired", timer_expired, m_expired);
  endtask

  int hold [4];

  initial begin
    reset = 1'b1; key_n = 4'hF; timer_start = 1'b0; timer_stop = 1'b0;
    step(); step();
    check_eq("rst_level", key_level, 4'h0);
    check_eq("rst_remaining", timer_remaining, 8'd0);
    check_eq("rst_running", timer_running, 1'b0);
    reset = 1'b0;
    step();

    // Clean press on key 1
    key_n = 4'b1101;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 5) check_eq("press_edge5_level", key_level, 4'b0000);
      if (e == 6) begin
        check_eq("press_edge6_level", key_level, 4'b0010);
        check_eq("press_edge6_pulse", key_press, 4'b0010);
      end
      if (e == 7) check_eq("press_edge7_pulse", key_press, 4'b0000);
    end

    // Release of key 1
    key_n = 4'hF;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) check_eq("release_edge5_level", key_level, 4'b0010);
      if (e == 6) check_eq("release_edge6_level", key_level, 4'b0000);
      check_eq("release_no_pulse", key_press, 4'b0000);
    end

    // Bounce on key 2: low 3, high 1, low 3, high
    for (int e = 0; e < 16; e++) begin
      key_n[2] = (e < 3 || (e >= 4 && e < 7)) ? 1'b0 : 1'b1;
      step();
      check_eq("bounce_level", key_level, 4'b0000);
      check_eq("bounce_pulse", key_press, 4'b0000);
    end
    key_n[2] = 1'b0;
    for (int e = 1; e <= 6; e++) step();
    check_eq("bounce_accept", key_level, 4'b0100);
    key_n = 4'hF;
    for (int e = 0; e < 8; e++) step();

    // Full round
    timer_start = 1'b1; step(); timer_start = 1'b0;
    check_eq("round_E_rem", timer_remaining, 8'd3);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 5)  check_eq("round_E5_rem", timer_remaining, 8'd2);
      if (k == 10) check_eq("round_E10_rem", timer_remaining, 8'd1);
      if (k == 15) begin
        check_eq("round_E15_rem", timer_remaining, 8'd0);
        check_eq("round_E15_exp", timer_expired, 1'b1);
        check_eq("round_E15_run", timer_running, 1'b0);
      end
      if (k == 16) check_eq("round_E16_exp", timer_expired, 1'b0);
    end

    // Start coincident with expiry
    timer_start = 1'b1; step(); timer_start = 1'b0;
    for (int k = 1; k <= 14; k++) step();
    timer_start = 1'b1; step(); timer_start = 1'b0;
    check_eq("collide_rem", timer_remaining, 8'd3);
    check_eq("collide_run", timer_running, 1'b1);
    check_eq("collide_exp", timer_expired, 1'b0);
    step();

    // Start and stop together
    timer_start = 1'b1; timer_stop = 1'b1; step();
    timer_start = 1'b0; timer_stop = 1'b0;
    check_eq("startstop_run", timer_running, 1'b0);
    check_eq("startstop_rem", timer_remaining, 8'd0);
    step();

    // Reset mid-round and mid-debounce
    timer_start = 1'b1; step(); timer_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) key_n = 4'b1110;
      step();
    end
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("midrst_level", key_level, 4'h0);
    check_eq("midrst_run", timer_running, 1'b0);
    check_eq("midrst_rem", timer_remaining, 8'd0);
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) check_eq("midrst_edge5_level", key_level, 4'b0000);
      if (e == 6) check_eq("midrst_edge6_level", key_level, 4'b0001);
    end
    key_n = 4'hF;
    for (int e = 0; e < 8; e++) step();

    // Randomized phase
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 8);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          key_n[i] = ~key_n[i];
          hold[i] = $urandom_range(1, 8);
        end
      end
      timer_start = ($urandom_range(0, 29) == 0);
      timer_stop  = ($urandom_range(0, 99) == 0);
      reset       = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0; timer_start = 1'b0; timer_stop = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
